// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;
  localparam int PC_ADDR_W  = 9;
  localparam int PERF_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE, RD_PC, LATCH, MEM_WAIT, VALID, INC, JUMP
  } fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// Fetch bus: PC strobes, instruction-memory read port and decode handshake.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = PC_ADDR_W,
  parameter int INSTR_W = 16
);
  logic               pc_inc, pc_read, pc_write;
  logic [ADDR_W-1:0]  pc_din, pc_dout;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid, instr_ready;

  modport master (
    output pc_inc, pc_read, pc_write, pc_din, imem_en, imem_addr,
           instr, instr_pc, instr_valid,
    input  pc_dout, imem_data, instr_ready
  );
  modport slave (
    input  pc_inc, pc_read, pc_write, pc_din, imem_en, imem_addr,
           instr, instr_pc, instr_valid,
    output pc_dout, imem_data, instr_ready
  );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch/flush event counters; body exists only when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_inc,
  input  logic                  flush_inc,
  output logic [PERF_CNT_W-1:0] fetch_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (fetch_inc && fetch_cnt != '1) fetch_cnt <= fetch_cnt + PERF_CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + PERF_CNT_W'(1);
    end
  end
endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Fetch FSM: read PC, read imem, present to decode, then increment or jump.
// Optional perf counters via FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = PC_ADDR_W,
  parameter int INSTR_W = 16,
  parameter int MEM_LAT = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  jump_req,
  input  logic [ADDR_W-1:0]     jump_addr,
  output logic                  busy,
`ifdef FETCH_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] fetch_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
`endif
  fetch_if.master               bus
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  fetch_state_e      state, nxt;
  logic              jump_pend;
  logic [ADDR_W-1:0] jaddr, addr_q, tgt;
  logic [CNT_W-1:0]  wcnt;
  logic              mem_last, pend_eff, hs, flush;

  // A request arriving this cycle counts as already pending and overrides the stored target.
  assign mem_last = (state == MEM_WAIT) && (wcnt == CNT_W'(MEM_LAT - 1));
  assign pend_eff = jump_pend | jump_req;
  assign tgt      = jump_req ? jump_addr : jaddr;
  assign hs       = (state == VALID) && bus.instr_ready;
  assign flush    = (mem_last && pend_eff) ||
                    ((state == VALID) && !bus.instr_ready && jump_req);

  // pc_dout is only valid during LATCH, so the address is forwarded then and held after.
  assign bus.imem_addr = (state == LATCH) ? bus.pc_dout : addr_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start && !halt) nxt = RD_PC;
      RD_PC:     nxt = LATCH;
      LATCH:     nxt = MEM_WAIT;
      MEM_WAIT:  if (mem_last) nxt = flush ? JUMP : VALID;
      VALID:     if (hs) nxt = pend_eff ? JUMP : INC;
                 else if (flush) nxt = JUMP;
      INC, JUMP: nxt = halt ? IDLE : RD_PC;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      bus.pc_inc      <= 1'b0;
      bus.pc_read     <= 1'b0;
      bus.pc_write    <= 1'b0;
      bus.pc_din      <= '0;
      bus.imem_en     <= 1'b0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      addr_q          <= '0;
      jaddr           <= '0;
      jump_pend       <= 1'b0;
      wcnt            <= '0;
    end else begin
      state           <= nxt;
      busy            <= (nxt != IDLE);
      bus.pc_read     <= (nxt == RD_PC);
      bus.pc_inc      <= (nxt == INC);
      bus.pc_write    <= (nxt == JUMP);
      bus.imem_en     <= (nxt == LATCH);
      bus.instr_valid <= (nxt == VALID);
      if (nxt == JUMP) bus.pc_din <= tgt;
      if (state == LATCH) begin
        addr_q       <= bus.pc_dout;
        bus.instr_pc <= bus.pc_dout;
      end
      wcnt <= (state == MEM_WAIT) ? wcnt + CNT_W'(1) : '0;
      if (mem_last) bus.instr <= bus.imem_data;
      if (state == JUMP)
        jump_pend <= 1'b0;
      else if (jump_req && (state inside {RD_PC, LATCH, MEM_WAIT, VALID})) begin
        jump_pend <= 1'b1;
        jaddr     <= jump_addr;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_inc (hs),
    .flush_inc (flush),
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
  );
`endif
endmodule
